// File: rtl/bf_uart_pkg.sv
// Shared types and constants for the Brainfuck UART output path.
package bf_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Width of a counter that must hold 0..clks_per_bit-1.
   function automatic int unsigned baud_cnt_w(input int unsigned clks_per_bit);
      return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/bf_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; reusable for the input path.
module sync_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign full    = (count_q == (ADDR_WIDTH+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   // A full FIFO still takes a push when the same edge frees a slot.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Next-state for pointers and occupancy; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      if (do_push && !do_pop)      count_d = count_q + (ADDR_WIDTH+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (ADDR_WIDTH+1)'(1);
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/bf_uart_tx.sv
// 8N1 UART transmitter fed by the CPU output strobe through a small FIFO.
module bf_uart_tx
   import bf_uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned FIFO_ADDR_WIDTH = 4,
   parameter int unsigned CLKS_PER_BIT    = 868
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     data_in_en,
   output logic                     tx,
   output logic                     busy,
   output logic                     overflow,
   output logic [FIFO_ADDR_WIDTH:0] fifo_count
);

   localparam int unsigned BAUD_W = baud_cnt_w(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   tx_state_t             state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  overflow_q, overflow_d;

   logic                  pop;
   logic                  fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  baud_tc;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (data_in_en),
      .pop   (pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign baud_tc  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign busy     = (state_q != IDLE) || !fifo_empty;
   assign overflow = overflow_q;

   // A byte is lost only when the FIFO is full and nothing leaves on this edge.
   always_comb begin
      overflow_d = overflow_q | (data_in_en & fifo_full & ~pop);
   end

   // Frame sequencer: next state, baud/bit counters, shifter, line level.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BAUD_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      tx      = STOP_BIT;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               state_d = START;
            end
         end
         START: begin
            tx = START_BIT;
            if (baud_tc) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            tx = shift_q[0];
            if (baud_tc) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = STOP;
               else                                 bit_d   = bit_q + BIT_W'(1);
            end
         end
         STOP: begin
            tx = STOP_BIT;
            if (baud_tc) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer and sticky overflow registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Randomised bench for bf_uart_tx against a frame-timing reference model.
module tb_bf_uart_tx;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 2;
   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned FRAME = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          data_in_en = 1'b0;
   logic          tx, busy, overflow;
   logic [AW:0]   fifo_count;

   int unsigned   n_chk  = 0;
   int unsigned   n_pass = 0;

   // Reference model: pending bytes, byte on the line, cycles left in frame.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] mcur = '0;
   int unsigned   mrem = 0;
   logic          movf = 1'b0;
   bit            mvalid = 1'b0;
   int unsigned   peak = 0;

   bf_uart_tx #(
      .DATA_WIDTH      (DW),
      .FIFO_ADDR_WIDTH (AW),
      .CLKS_PER_BIT    (CPB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_in_en (data_in_en),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h want=%0h", tag, got, exp);
   endtask

   function automatic logic exp_tx();
      int unsigned b;
      if (mrem == 0) return 1'b1;
      b = (FRAME - mrem) / CPB;
      if (b == 0)  return 1'b0;
      if (b <= DW) return mcur[b-1];
      return 1'b1;
   endfunction

   task automatic model_edge(input logic r, input logic en, input logic [DW-1:0] d);
      bit pop_now;
      if (r) begin
         mq.delete();
         mrem   = 0;
         movf   = 1'b0;
         mvalid = 1'b1;
         return;
      end
      // A new frame starts when the line is idle or on the last stop cycle.
      pop_now = (mq.size() != 0) && (mrem <= 1);
      if (pop_now) mcur = mq.pop_front();
      if (en) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else                   movf = 1'b1;
      end
      if (pop_now)       mrem = FRAME;
      else if (mrem > 0) mrem--;
   endtask

   task automatic step(input logic r, input logic en, input logic [DW-1:0] d);
      rst = r; data_in_en = en; data_in = d;
      @(negedge clk);
      if (mvalid) begin
         chk("tx", tx, exp_tx());
         chk("busy", busy, (mrem != 0) || (mq.size() != 0));
         chk("fifo_count", fifo_count, mq.size());
         chk("overflow", overflow, movf);
      end
      if (fifo_count > peak) peak = fifo_count;
      model_edge(r, en, d);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int unsigned n = 0;
      while ((mrem != 0 || mq.size() != 0) && n < 600) begin
         step(0, 0, '0);
         n++;
      end
      chk(tag, (n < 600), 1);
   endtask

   initial begin
      int unsigned n;
      int unsigned dens;

      // Reset state
      repeat (3) step(1, 0, '0);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_cnt", fifo_count, 0);

      // Single byte 0x41: tx falls two cycles after the strobe, busy drops 42 later
      repeat (9) step(0, 0, '0);
      step(0, 1, 8'h41);
      chk("lat_cnt", fifo_count, 1);
      chk("lat_tx_hi", tx, 1);
      step(0, 0, '0);
      chk("lat_tx_lo", tx, 0);
      n = 1;
      while (busy && n < 100) begin
         step(0, 0, '0);
         n++;
      end
      chk("busy_fall", n + 1, 42);
      chk("single_ovf", overflow, 0);

      // Five-strobe burst into a depth-4 FIFO
      peak = 0;
      for (int i = 1; i <= 5; i++) step(0, 1, DW'(i));
      drain("burst5_drain");
      chk("burst5_peak", peak, 4);
      chk("burst5_ovf", overflow, 0);

      // Full FIFO, push on the stop-final pop cycle is accepted
      for (int i = 0; i < 5; i++) step(0, 1, DW'(8'h61 + i));
      n = 0;
      while (!(mrem == 1 && mq.size() == DEPTH) && n < 100) begin
         step(0, 0, '0);
         n++;
      end
      chk("aa_reach", (n < 100), 1);
      step(0, 1, 8'hAA);
      chk("aa_cnt", fifo_count, 4);
      chk("aa_ovf", overflow, 0);
      drain("aa_drain");

      // Seven-strobe burst: two bytes dropped, overflow sticks
      for (int i = 0; i < 7; i++) step(0, 1, DW'(8'h10 + i));
      chk("b7_ovf", overflow, 1);
      drain("b7_drain");
      step(0, 1, 8'hC3);
      drain("b7_drain2");
      chk("b7_ovf_hold", overflow, 1);

      // Reset in the middle of data bit 3 of 0x5A with two bytes queued
      step(1, 0, '0);
      step(0, 1, 8'h5A);
      step(0, 1, 8'h11);
      step(0, 1, 8'h22);
      n = 0;
      while (mrem != FRAME - 4 * CPB - 1 && n < 100) begin
         step(0, 0, '0);
         n++;
      end
      chk("mid_bit3", tx, 1);
      chk("mid_cnt", fifo_count, 2);
      step(1, 0, '0);
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cnt", fifo_count, 0);
      step(0, 1, 8'h33);
      drain("post_rst_drain");

      // Idle line after reset
      step(1, 0, '0);
      repeat (1000) step(0, 0, '0);

      // Random traffic with varying strobe density and rare resets
      for (int ph = 0; ph < 6; ph++) begin
         case ($urandom_range(0, 3))
            0: dens = 2;
            1: dens = 10;
            2: dens = 50;
            default: dens = 90;
         endcase
         for (int c = 0; c < 500; c++) begin
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 99) < dens),
                 DW'($urandom));
         end
      end
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bf_uart_tx.md
Name: bf_uart_tx

Overview:
- Downstream output stage of the Brainfuck processor.
- Consumes the CPU's one-cycle output strobe (data_out / data_out_en) and buffers bytes in a small FIFO.
- Serialises bytes onto an 8N1 UART line.
- The CPU cannot stall, so the block absorbs bursts and flags lost bytes instead of back-pressuring.

Parameters:
- DATA_WIDTH, 8: bits per character; matches CPU data width.
- FIFO_ADDR_WIDTH, 4: FIFO depth = 2**FIFO_ADDR_WIDTH entries (16).
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  byte from the CPU output bus.
- data_in_en  input  1  high for exactly the cycles where data_in is valid; one byte per high cycle.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- overflow  output  1  sticky; set when a byte is dropped.
- fifo_count  output  FIFO_ADDR_WIDTH+1  entries currently buffered.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, bit/baud counters=0.
- Reset mid-frame:
  - Frame is aborted and tx=1 on the next cycle.
  - FIFO contents are discarded.
- FIFO write:
  - On an edge with data_in_en=1 and FIFO not full, data_in is enqueued.
  - If full and no pop on the same edge, the byte is dropped and overflow<=1.
  - Overflow holds until rst.
- Simultaneous push and pop:
  - Push is accepted even when the FIFO is full; fifo_count is unchanged.
  - Pop of an empty FIFO never occurs: the FSM only pops when fifo_count!=0 in the current cycle, so there is no bypass.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count!=0, pop the head into shift_reg and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[0], LSB first, each bit held CLKS_PER_BIT cycles.
    - Shift right after each bit.
    - After bit DATA_WIDTH-1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - At the final cycle, if fifo_count!=0, pop and go directly to START (back-to-back frames, no extra idle).
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and advances the bit on terminal count. It is zeroed on every state entry.
- Latency:
  - data_in_en high in cycle N with the FSM in IDLE and the FIFO empty: byte is visible in cycle N+1 (fifo_count=1).
  - Popped at the end of N+1; tx falls at cycle N+2.
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
- busy = (state!=IDLE) || (fifo_count!=0), registered-state-derived, no combinational path from data_in_en.
- FIFO pointers wrap modulo 2**FIFO_ADDR_WIDTH. fifo_count ranges 0..2**FIFO_ADDR_WIDTH.
- CPU halt repeatedly executing output: every data_in_en cycle is a distinct byte; no deduplication.

Decomposition:
- Package bf_uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - Frame constants: START_BIT=0, STOP_BIT=1.
  - Helper localparam for baud counter width, $clog2(CLKS_PER_BIT).
- Sub-module sync_fifo:
  - Parameterised DATA_WIDTH and ADDR_WIDTH; synchronous rst.
  - Ports: push, pop, din, dout (first-word fall-through), full, empty, count.
  - Reusable later for an input (',') path.
- bf_uart_tx holds the FSM, baud counter, shift register and overflow flag.

Test Plan (CLKS_PER_BIT=4, FIFO_ADDR_WIDTH=2):
- Single byte 0x41 strobed at cycle 10 -> tx low at cycle 12 for 4 cycles, then data bits 1,0,0,0,0,0,1,0 each 4 cycles, then stop high. busy falls at cycle 52. overflow=0.
- Five-strobe burst 0x01..0x05 on consecutive cycles -> all five frames transmitted back-to-back with no idle gap between stop and start. fifo_count peaks at 4, overflow stays 0.
  - Byte 1 is popped before byte 5 arrives, so the depth-4 FIFO holds 4 pending bytes.
- Burst of 7 consecutive strobes 0x10..0x16 -> 0x10..0x14 transmitted, 0x15 and 0x16 dropped. overflow=1 from the edge after the first drop, held through later traffic until rst.
- FIFO full with the STOP final cycle popping in the same cycle as data_in_en=0xAA -> 0xAA accepted, fifo_count stays 4, overflow stays 0, and 0xAA is sent last.
- rst asserted during DATA bit 3 of 0x5A with 2 bytes queued -> next cycle tx=1, busy=0, fifo_count=0. A fresh strobe of 0x33 afterwards transmits correctly.
- Idle-line check: no strobes for 1000 cycles after reset -> tx constant 1, busy 0, fifo_count 0.
